// File: rtl/battleship_pkg.sv
// ============================================================================
// Module   : battleship_pkg
// Purpose  : Shared board constants, placement state type and cell indexing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package battleship_pkg;

    localparam int DEFAULT_BOARD_N = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLACING = 2'd1,
        ST_DONE    = 2'd2
    } place_state_t;

    function automatic int cell_idx(input int row, input int col, input int n = DEFAULT_BOARD_N);
        return row * n + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/placement_cursor.sv
// ============================================================================
// Module   : placement_cursor
// Purpose  : Saturating board cursor; one move per cycle, up > down > left > right.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module placement_cursor #(
    parameter int BOARD_N = 5,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col
);

    localparam logic [CW-1:0] c_max_pos = CW'(BOARD_N - 1);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;

    // The highest-priority pressed move is selected first; a wall then just
    // suppresses it rather than letting a lower-priority move through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (en) begin
            if (up) begin
                if (r_row != '0) r_row <= r_row - 1'b1;
            end else if (down) begin
                if (r_row != c_max_pos) r_row <= r_row + 1'b1;
            end else if (left) begin
                if (r_col != '0) r_col <= r_col - 1'b1;
            end else if (right) begin
                if (r_col != c_max_pos) r_col <= r_col + 1'b1;
            end
        end
    end

    assign row = r_row;
    assign col = r_col;

endmodule

`default_nettype wire

// File: rtl/ship_placement_ctrl.sv
// ============================================================================
// Module   : ship_placement_ctrl
// Purpose  : Colocation-phase controller: latches ship amount, places ships.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ship_placement_ctrl
    import battleship_pkg::*;
#(
    parameter int BOARD_N = DEFAULT_BOARD_N,
    parameter int CW      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ships_decided,
    input  logic [2:0]             player_ship_amount_define,
    input  logic                   colocation_ships_State,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_place,
    output logic [CW-1:0]          cursor_row,
    output logic [CW-1:0]          cursor_col,
    output logic [BOARD_N*BOARD_N-1:0] ship_grid,
    output logic [2:0]             ships_placed,
    output logic [2:0]             ships_remaining,
    output logic                   placing_active,
    output logic                   finished_placing,
    output logic                   place_error
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IW    = $clog2(CELLS);

    place_state_t     r_state, w_state_nx;
    logic [CELLS-1:0] r_grid, w_grid_nx;
    logic [2:0]       r_placed, w_placed_nx;
    logic [2:0]       r_amount, w_amount_nx;
    logic             r_err, w_err_nx;
    logic             w_cur_clear;
    logic             w_cur_en;
    logic [CW-1:0]    w_row;
    logic [CW-1:0]    w_col;
    logic [IW-1:0]    w_idx;

    assign w_idx = IW'(cell_idx(int'(w_row), int'(w_col), BOARD_N));

    placement_cursor #(
        .BOARD_N (BOARD_N),
        .CW      (CW)
    ) u_cursor (
        .clk   (clk),
        .rst   (rst),
        .clear (w_cur_clear),
        .en    (w_cur_en),
        .up    (btn_up),
        .down  (btn_down),
        .left  (btn_left),
        .right (btn_right),
        .row   (w_row),
        .col   (w_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grid   <= '0;
            r_placed <= '0;
            r_amount <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_grid   <= w_grid_nx;
            r_placed <= w_placed_nx;
            r_amount <= w_amount_nx;
            r_err    <= w_err_nx;
        end
    end

    // Losing the placement phase takes precedence over a same-cycle place.
    always_comb begin
        w_state_nx  = r_state;
        w_grid_nx   = r_grid;
        w_placed_nx = r_placed;
        w_amount_nx = r_amount;
        w_err_nx    = 1'b0;
        w_cur_clear = 1'b0;
        w_cur_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ships_decided && (player_ship_amount_define != 3'd0) && colocation_ships_State) begin
                    w_amount_nx = player_ship_amount_define;
                    w_grid_nx   = '0;
                    w_placed_nx = 3'd0;
                    w_cur_clear = 1'b1;
                    w_state_nx  = ST_PLACING;
                end
            end
            ST_PLACING: begin
                if (!colocation_ships_State) begin
                    w_state_nx = ST_IDLE;
                end else if (btn_place) begin
                    if (r_grid[w_idx]) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_grid_nx[w_idx] = 1'b1;
                        w_placed_nx      = r_placed + 3'd1;
                        if (w_placed_nx == r_amount) w_state_nx = ST_DONE;
                    end
                end else begin
                    w_cur_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (!colocation_ships_State) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign cursor_row       = w_row;
    assign cursor_col       = w_col;
    assign ship_grid        = r_grid;
    assign ships_placed     = r_placed;
    assign ships_remaining  = r_amount - r_placed;
    assign placing_active   = (r_state == ST_PLACING);
    assign finished_placing = (r_state == ST_DONE);
    assign place_error      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ship_placement_ctrl.sv
// ============================================================================
// Module   : tb_ship_placement_ctrl
// Purpose  : Self-checking bench: directed vector table, hand sequences, random.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ship_placement_ctrl;

    localparam int N  = 5;
    localparam int CW = 3;

    typedef struct packed {
        logic       u, d, l, r, p, coloc, dec;
        logic [2:0] amt;
    } stim_t;

    typedef struct {
        stim_t       s;
        int          row, col, placed, rem;
        bit          act, done, err;
        logic [24:0] grid;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ships_decided;
    logic [2:0]        amount;
    logic              coloc;
    logic              b_up, b_down, b_left, b_right, b_place;
    logic [CW-1:0]     cursor_row, cursor_col;
    logic [N*N-1:0]    ship_grid;
    logic [2:0]        ships_placed, ships_remaining;
    logic              placing_active, finished_placing, place_error;

    ship_placement_ctrl #(.BOARD_N(N), .CW(CW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .ships_decided             (ships_decided),
        .player_ship_amount_define (amount),
        .colocation_ships_State    (coloc),
        .btn_up                    (b_up),
        .btn_down                  (b_down),
        .btn_left                  (b_left),
        .btn_right                 (b_right),
        .btn_place                 (b_place),
        .cursor_row                (cursor_row),
        .cursor_col                (cursor_col),
        .ship_grid                 (ship_grid),
        .ships_placed              (ships_placed),
        .ships_remaining           (ships_remaining),
        .placing_active            (placing_active),
        .finished_placing          (finished_placing),
        .place_error               (place_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 = waiting, 1 = placing, 2 = finished.
    int m_phase, m_lat, m_placed, m_row, m_col;
    bit m_err;
    bit m_board [N][N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] m_grid();
        logic [24:0] g;
        g = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                g[i*N+j] = m_board[i][j];
        return g;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_lat = 0; m_placed = 0; m_row = 0; m_col = 0; m_err = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m_board[i][j] = 0;
    endtask

    task automatic model_step(input stim_t s);
        m_err = 0;
        if (m_phase == 0) begin
            if (s.dec && s.amt != 0 && s.coloc) begin
                m_lat = s.amt; m_placed = 0; m_row = 0; m_col = 0; m_phase = 1;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        m_board[i][j] = 0;
            end
        end else if (!s.coloc) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (s.p) begin
                if (m_board[m_row][m_col]) m_err = 1;
                else begin
                    m_board[m_row][m_col] = 1;
                    m_placed++;
                    if (m_placed == m_lat) m_phase = 2;
                end
            end else if (s.u) m_row = (m_row > 0)   ? m_row - 1 : 0;
            else if (s.d)     m_row = (m_row < N-1) ? m_row + 1 : N-1;
            else if (s.l)     m_col = (m_col > 0)   ? m_col - 1 : 0;
            else if (s.r)     m_col = (m_col < N-1) ? m_col + 1 : N-1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_row"},    32'(cursor_row),       32'(m_row));
        chk({tag, "_col"},    32'(cursor_col),       32'(m_col));
        chk({tag, "_placed"}, 32'(ships_placed),     32'(m_placed));
        chk({tag, "_rem"},    32'(ships_remaining),  32'(m_lat - m_placed));
        chk({tag, "_active"}, 32'(placing_active),   32'(m_phase == 1));
        chk({tag, "_done"},   32'(finished_placing), 32'(m_phase == 2));
        chk({tag, "_err"},    32'(place_error),      32'(m_err));
        chk({tag, "_grid"},   32'(ship_grid),        32'(m_grid()));
    endtask

    // Drive inputs between edges, advance one clock, sample 1 ns after it.
    task automatic apply(input stim_t s, input string tag);
        b_up = s.u; b_down = s.d; b_left = s.l; b_right = s.r; b_place = s.p;
        coloc = s.coloc; ships_decided = s.dec; amount = s.amt;
        model_step(s);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    function automatic stim_t mk(input bit u, d, l, r, p, c, dec, input int amt);
        stim_t s;
        s = '{u: u, d: d, l: l, r: r, p: p, coloc: c, dec: dec, amt: 3'(amt)};
        return s;
    endfunction

    function automatic vec_t v(input stim_t s, input int row, col, placed, rem,
                               input bit act, done, err, input logic [24:0] grid);
        vec_t x;
        x.s = s; x.row = row; x.col = col; x.placed = placed; x.rem = rem;
        x.act = act; x.done = done; x.err = err; x.grid = grid;
        return x;
    endfunction

    vec_t tbl [25];

    initial begin
        //                 u d l r p c dec amt    row col plc rem act dn er grid
        tbl[0]  = v(mk(0,0,0,0,0,1,1,0), 0,0,0,0, 0,0,0, 25'h0);
        tbl[1]  = v(mk(0,0,0,0,0,1,1,3), 0,0,0,3, 1,0,0, 25'h0);
        tbl[2]  = v(mk(0,0,0,0,1,1,0,0), 0,0,1,2, 1,0,0, 25'h1);
        tbl[3]  = v(mk(0,0,0,1,0,1,0,0), 0,1,1,2, 1,0,0, 25'h1);
        tbl[4]  = v(mk(0,0,0,1,1,1,0,0), 0,1,2,1, 1,0,0, 25'h3);
        tbl[5]  = v(mk(0,1,0,0,0,1,0,0), 1,1,2,1, 1,0,0, 25'h3);
        tbl[6]  = v(mk(0,0,0,0,1,1,0,0), 1,1,3,0, 0,1,0, 25'h43);
        tbl[7]  = v(mk(0,0,0,1,0,1,0,0), 1,1,3,0, 0,1,0, 25'h43);
        tbl[8]  = v(mk(0,0,0,0,0,0,0,0), 1,1,3,0, 0,0,0, 25'h43);
        tbl[9]  = v(mk(0,0,0,0,0,1,1,2), 0,0,0,2, 1,0,0, 25'h0);
        tbl[10] = v(mk(0,0,0,0,1,1,0,0), 0,0,1,1, 1,0,0, 25'h1);
        tbl[11] = v(mk(0,0,0,0,1,1,0,0), 0,0,1,1, 1,0,1, 25'h1);
        tbl[12] = v(mk(0,0,0,0,0,1,0,0), 0,0,1,1, 1,0,0, 25'h1);
        tbl[13] = v(mk(1,0,1,0,0,1,0,0), 0,0,1,1, 1,0,0, 25'h1);
        tbl[14] = v(mk(0,1,0,0,0,1,0,0), 1,0,1,1, 1,0,0, 25'h1);
        tbl[15] = v(mk(0,1,0,0,0,1,0,0), 2,0,1,1, 1,0,0, 25'h1);
        tbl[16] = v(mk(0,1,0,0,0,1,0,0), 3,0,1,1, 1,0,0, 25'h1);
        tbl[17] = v(mk(0,1,0,0,0,1,0,0), 4,0,1,1, 1,0,0, 25'h1);
        tbl[18] = v(mk(0,1,0,0,0,1,0,0), 4,0,1,1, 1,0,0, 25'h1);
        tbl[19] = v(mk(1,0,0,0,0,1,0,0), 3,0,1,1, 1,0,0, 25'h1);
        tbl[20] = v(mk(1,0,0,0,0,1,0,0), 2,0,1,1, 1,0,0, 25'h1);
        tbl[21] = v(mk(0,0,0,1,0,1,0,0), 2,1,1,1, 1,0,0, 25'h1);
        tbl[22] = v(mk(0,0,0,1,0,1,0,0), 2,2,1,1, 1,0,0, 25'h1);
        tbl[23] = v(mk(1,0,1,0,0,1,0,0), 1,2,1,1, 1,0,0, 25'h1);
        tbl[24] = v(mk(0,0,0,0,0,1,1,7), 1,2,1,1, 1,0,0, 25'h1);

        rst = 1'b1;
        {b_up, b_down, b_left, b_right, b_place, coloc, ships_decided} = '0;
        amount = 3'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_row",    32'(cursor_row),       32'd0);
        chk("reset_col",    32'(cursor_col),       32'd0);
        chk("reset_grid",   32'(ship_grid),        32'd0);
        chk("reset_placed", 32'(ships_placed),     32'd0);
        chk("reset_rem",    32'(ships_remaining),  32'd0);
        chk("reset_active", 32'(placing_active),   32'd0);
        chk("reset_done",   32'(finished_placing), 32'd0);
        chk("reset_err",    32'(place_error),      32'd0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_t_row", i),    32'(cursor_row),       32'(tbl[i].row));
            chk($sformatf("vec%0d_t_col", i),    32'(cursor_col),       32'(tbl[i].col));
            chk($sformatf("vec%0d_t_placed", i), 32'(ships_placed),     32'(tbl[i].placed));
            chk($sformatf("vec%0d_t_rem", i),    32'(ships_remaining),  32'(tbl[i].rem));
            chk($sformatf("vec%0d_t_active", i), 32'(placing_active),   32'(tbl[i].act));
            chk($sformatf("vec%0d_t_done", i),   32'(finished_placing), 32'(tbl[i].done));
            chk($sformatf("vec%0d_t_err", i),    32'(place_error),      32'(tbl[i].err));
            chk($sformatf("vec%0d_t_grid", i),   32'(ship_grid),        32'(tbl[i].grid));
        end

        // Asynchronous reset in the middle of a cycle with two ships down.
        apply(mk(0,0,0,0,0,0,0,0), "abort");
        apply(mk(0,0,0,0,0,1,1,5), "accept5");
        chk("accept5_grid_cleared", 32'(ship_grid), 32'd0);
        apply(mk(0,0,0,0,1,1,0,0), "h_place1");
        apply(mk(0,0,0,1,0,1,0,0), "h_right");
        apply(mk(0,0,0,0,1,1,0,0), "h_place2");
        chk("h_placed2", 32'(ships_placed), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_row",    32'(cursor_row),       32'd0);
        chk("arst_col",    32'(cursor_col),       32'd0);
        chk("arst_grid",   32'(ship_grid),        32'd0);
        chk("arst_placed", 32'(ships_placed),     32'd0);
        chk("arst_rem",    32'(ships_remaining),  32'd0);
        chk("arst_active", 32'(placing_active),   32'd0);
        chk("arst_done",   32'(finished_placing), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            stim_t s;
            s.u     = ($urandom_range(0, 3) == 0);
            s.d     = ($urandom_range(0, 3) == 0);
            s.l     = ($urandom_range(0, 3) == 0);
            s.r     = ($urandom_range(0, 3) == 0);
            s.p     = ($urandom_range(0, 4) == 0);
            s.coloc = ($urandom_range(0, 39) != 0);
            s.dec   = ($urandom_range(0, 5) == 0);
            s.amt   = 3'($urandom_range(0, 7));
            apply(s, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ship_placement_ctrl.md
# ship_placement_ctrl

Ship-placement controller for the Battleship game flow: the consuming end of the ship-amount handshake. When the decision stage raises `ships_decided` with a nonzero `player_ship_amount_define`, this block latches the amount and runs the colocation phase. It moves a board cursor on button pulses, places single-cell ships on unoccupied cells and raises `finished_placing` once the latched count is reached. Its outputs feed the VGA board renderer and the top-level game FSM.

## Interface
- `BOARD_N`, default 5: board edge length in cells (cells = BOARD_N*BOARD_N, row-major index = row*BOARD_N + col).
- `CW`, default 3: cursor coordinate width; must satisfy 2^CW ≥ BOARD_N.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ships_decided`  in  1  amount-valid from the decision stage.
- `player_ship_amount_define`  in  3  number of ships to place (1..7).
- `colocation_ships_State`  in  1  game FSM is in the placement phase.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced single-cycle move pulses.
- `btn_place`  in  1  debounced single-cycle place pulse.
- `cursor_row`, `cursor_col`  out  CW each  current cursor position.
- `ship_grid`  out  BOARD_N*BOARD_N  occupancy bitmap, 1 = ship.
- `ships_placed`  out  3  ships placed so far.
- `ships_remaining`  out  3  latched amount minus `ships_placed`.
- `placing_active`  out  1  high in PLACING.
- `finished_placing`  out  1  high in DONE.
- `place_error`  out  1  one-cycle pulse on a rejected placement.

## Operation
- States: IDLE, PLACING, DONE.
- IDLE: `ships_decided`=1, amount ≠ 0 and `colocation_ships_State`=1 → latch amount, clear `ship_grid`, `ships_placed`=0, cursor to (0,0), go PLACING. Amount 0 is ignored; the block stays in IDLE.
- PLACING, place: `btn_place` on an empty cell sets the cell bit and increments `ships_placed`. On an occupied cell it sets nothing and pulses `place_error`.
- PLACING, completion: when the increment makes `ships_placed` equal the latched amount, go DONE.
- PLACING, move: cursor saturates at 0 and BOARD_N-1; no wrap. Moving into a wall is silently ignored.
- PLACING, multiple buttons in one cycle: `btn_place` wins and all moves are dropped. Among moves, priority is up > down > left > right, and only one move is applied.
- PLACING, retriggers: `ships_decided` is ignored; the latched amount is frozen.
- Abort: `colocation_ships_State` falling in PLACING or DONE → IDLE. `ship_grid` and `ships_placed` are retained for display until the next accept.
- DONE: buttons are ignored and `finished_placing` stays high until `colocation_ships_State` falls.
- Arithmetic: `ships_remaining` = latched − placed, 3-bit, never negative. Amount ≤ 7 < 25, so the board never fills before completion.

## Timing
- Reset values: all outputs 0, cursor (0,0), latched amount 0, state IDLE.
- Accept latency: `ships_decided` sampled at edge N → `placing_active`=1 after edge N.
- Place/move: button sampled at edge N → grid, count and cursor updated after edge N. `place_error` is high for exactly cycle N..N+1.
- Completion: the final place at edge N sets `finished_placing` after edge N, the same edge as the grid update.
- Reset asserted mid-placement clears everything immediately, with no clock required. Deassertion is synchronous to the clock at the system level.
- The producer updates on the opposite clock edge, which gives a half-cycle setup margin; no extra synchronizer is needed.

## Structure
- `battleship_pkg`: `BOARD_N` default, state enum `place_state_t`, function `cell_idx(row,col)`. Shared with the decision stage and the renderer.
- Sub-module `placement_cursor`: saturating row/col registers with move priority and enable. This module holds the FSM, grid, counters and error pulse.

## Test plan
- Reset in PLACING with 2 ships placed → immediately all outputs 0, state IDLE.
- Accept amount 3, place at (0,0), right, (0,1), down, (1,1) → `ship_grid` bits 0, 1, 6 set; `finished_placing`=1 on the third place edge; `ships_remaining`=0.
- Amount 2, place (0,0) twice → second place pulses `place_error` for 1 cycle; `ships_placed` stays 1.
- Cursor at (0,0), up and left pulses → stays (0,0). Five downs on a 5×5 board → row saturates at 4.
- Same cycle: `btn_place` + `btn_right` → ship at the old cursor, cursor unchanged. `btn_up` + `btn_left` at (2,2) → cursor (1,2).
- `ships_decided` with amount 0 → remains IDLE. `colocation_ships_State` drops mid-PLACING → IDLE with grid retained. New accept → grid cleared.
